// File: rtl/conv_display_sequencer.sv
// conv_display_sequencer
// Reads back the serial / 3x3 / 2x2 convolution result banks (four results
// each) and presents them one at a time to the display driver. Each result is
// held for DWELL_MAX+1 cycles; skip advances early.
// Optional build macro: DISP_HOLD_EN adds a 'hold' input that freezes the
// dwell counter (and masks skip) while a result is being shown.
module conv_display_sequencer #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 27,
    parameter int DWELL_MAX = 99999999,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        bank_mask,
    input  logic              skip,
`ifdef DISP_HOLD_EN
    input  logic              hold,
`endif
    output logic              rd_en,
    output logic [1:0]        rd_bank,
    output logic [1:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              dis_en,
    output logic [DATA_W-1:0] dis_data,
    output logic [1:0]        dis_bank,
    output logic [1:0]        dis_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_MAX);
    localparam logic [1:0]       WAIT_LAST  = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SHOW,
        S_FINISH
    } state_t;

    state_t              state_reg, state_next;
    logic [2:0]          mask_reg, mask_next;
    logic [1:0]          bank_reg, bank_next;   // current position, also drives rd_bank
    logic [1:0]          idx_reg, idx_next;     // current position, also drives rd_addr
    logic [CNT_W-1:0]    dwell_reg;
    logic [1:0]          wait_reg;
    logic [DATA_W-1:0]   dis_data_reg;
    logic [1:0]          dis_bank_reg;
    logic [1:0]          dis_idx_reg;
    logic                dis_en_reg;

    logic                hold_eff;
    logic                advance;
    logic                capture;
    logic [1:0]          low_bank;
    logic [1:0]          up_bank;
    logic                up_found;

`ifdef DISP_HOLD_EN
    assign hold_eff = hold;
`else
    assign hold_eff = 1'b0;
`endif

    // Bank search: lowest bank enabled by the incoming mask, and the next
    // enabled bank above the current one in the latched mask.
    always_comb begin
        low_bank = 2'd0;
        for (int b = 2; b >= 0; b--) begin
            if (bank_mask[b]) begin
                low_bank = 2'(b);
            end
        end
        up_bank  = 2'd0;
        up_found = 1'b0;
        for (int b = 2; b >= 0; b--) begin
            if (mask_reg[b] && (2'(b) > bank_reg)) begin
                up_bank  = 2'(b);
                up_found = 1'b1;
            end
        end
    end

    // Next-state and position logic for the sequencer FSM.
    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        bank_next  = bank_reg;
        idx_next   = idx_reg;
        advance    = (state_reg == S_SHOW) && !hold_eff &&
                     (skip || (dwell_reg == DWELL_LAST));
        capture    = (state_reg == S_WAIT) && (wait_reg == WAIT_LAST);
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (bank_mask != 3'b000) begin
                        mask_next  = bank_mask;
                        bank_next  = low_bank;
                        idx_next   = 2'd0;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_FINISH;
                    end
                end
            end
            S_FETCH: state_next = S_WAIT;
            S_WAIT: begin
                if (capture) begin
                    state_next = S_SHOW;
                end
            end
            S_SHOW: begin
                if (advance) begin
                    if (idx_reg != 2'd3) begin
                        idx_next   = idx_reg + 2'd1;
                        state_next = S_FETCH;
                    end else if (up_found) begin
                        bank_next  = up_bank;
                        idx_next   = 2'd0;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_FINISH;
                    end
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State, latched mask and read position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            mask_reg  <= 3'b000;
            bank_reg  <= 2'd0;
            idx_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            bank_reg  <= bank_next;
            idx_reg   <= idx_next;
        end
    end

    // Dwell counter: runs only in SHOW, clears on advance, freezes on hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_reg <= '0;
        end else if ((state_reg != S_SHOW) || advance) begin
            dwell_reg <= '0;
        end else if (!hold_eff) begin
            dwell_reg <= dwell_reg + 1'b1;
        end
    end

    // Read-latency counter for the WAIT state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_reg <= 2'd0;
        end else if (state_reg == S_WAIT) begin
            wait_reg <= wait_reg + 2'd1;
        end else begin
            wait_reg <= 2'd0;
        end
    end

    // Display capture; dis_en stays up across refetches and drops for FINISH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dis_data_reg <= '0;
            dis_bank_reg <= 2'd0;
            dis_idx_reg  <= 2'd0;
            dis_en_reg   <= 1'b0;
        end else begin
            if (capture) begin
                dis_data_reg <= rd_data;
                dis_bank_reg <= bank_reg;
                dis_idx_reg  <= idx_reg;
                dis_en_reg   <= 1'b1;
            end else if (state_next == S_FINISH) begin
                dis_en_reg   <= 1'b0;
            end
        end
    end

    assign rd_en    = (state_reg == S_FETCH);
    assign rd_bank  = bank_reg;
    assign rd_addr  = idx_reg;
    assign dis_en   = dis_en_reg;
    assign dis_data = dis_data_reg;
    assign dis_bank = dis_bank_reg;
    assign dis_idx  = dis_idx_reg;
    assign busy     = (state_reg != S_IDLE);
    assign done     = (state_reg == S_FINISH);

endmodule

// File: doc/conv_display_sequencer.md
Name: conv_display_sequencer

Overview:
- Sequences readback of the convolution results for display after the compute modes finish: four results each from the serial, 3x3-parallel and 2x2-parallel result banks.
- Sits between the top-level mode controller (start/done handshake) and the result memories (rd_en/bank/addr) and the display driver (dis_en/dis_data/dis_bank/dis_idx).
- Holds each result for a programmable dwell time; a skip input advances early.

Parameters:
DATA_W, 8, width of one stored result and of dis_data
CNT_W, 27, dwell counter width
DWELL_MAX, 99999999, terminal dwell count; each result shows DWELL_MAX+1 cycles (1 s at 100 MHz)
RD_LAT, 1, result memory read latency in cycles (1..3)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a display pass
bank_mask  input  3  bank enable, sampled with start: bit0 serial, bit1 3x3, bit2 2x2
skip  input  1  advance to next result immediately (SHOW only)
rd_en  output  1  result memory read strobe
rd_bank  output  2  bank select 0..2
rd_addr  output  2  result index 0=C11 1=C12 2=C21 3=C22
rd_data  input  DATA_W  read data, valid RD_LAT cycles after rd_en
dis_en  output  1  display enable
dis_data  output  DATA_W  captured result being shown
dis_bank  output  2  bank of dis_data
dis_idx  output  2  index of dis_data
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse at end of pass

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; dwell counter 0; latched mask 0. Reset mid-pass abandons it with no done pulse.
- States:
  - IDLE: waits for start.
  - FETCH: 1 cycle.
  - WAIT: RD_LAT cycles.
  - SHOW: dwell.
  - FINISH: 1 cycle.
- IDLE + start:
  - mask!=0: latch mask; point to the lowest enabled bank, index 0; busy=1; go to FETCH.
  - mask==0: go to FINISH; busy=1 for that one cycle; no reads.
- start while busy: ignored, and the latched mask is unchanged.
- FETCH: rd_en=1 with rd_bank/rd_addr = current position; otherwise rd_en=0, rd_bank/rd_addr hold.
- WAIT: rd_data is captured into dis_data at the clock edge ending the last WAIT cycle. dis_bank/dis_idx update on the same edge. Next state is SHOW.
- Latency: start at cycle 0 -> FETCH cycle 1 -> first SHOW cycle 2+RD_LAT.
- SHOW: dis_en=1. The dwell counter counts 0..DWELL_MAX. The pass advances when counter==DWELL_MAX or skip=1.
  - skip and terminal count in the same cycle produce a single advance.
  - The counter clears on every advance and in every non-SHOW state.
- Advance order: index 0->1->2->3 within a bank, then the next enabled bank in ascending order. Disabled banks are skipped with zero cycles spent.
  - If another result remains: go to FETCH. During refetch, dis_en stays 1 and dis_data holds the previous result.
  - After index 3 of the highest enabled bank: go to FINISH.
- FINISH: done=1 for one cycle, dis_en=0, busy=0 from the next cycle, return to IDLE. dis_data/dis_bank/dis_idx keep the last values until the next capture.
- A start in the FINISH cycle is ignored; start is accepted in IDLE only.
- Counter arithmetic is unsigned CNT_W bits; it never wraps because it clears at DWELL_MAX. DWELL_MAX must be < 2^CNT_W. DWELL_MAX=0 gives 1-cycle dwell.

Optional Feature:
- Macro: DISP_HOLD_EN.
- Defined: adds input port hold (1 bit).
  - While hold=1 in SHOW, the dwell counter freezes and skip is ignored.
  - hold has no effect in other states.
  - Releasing hold resumes counting from the frozen value.
- Undefined: no hold port; behaviour exactly as above.

Test Plan:
- Bench params: DWELL_MAX=3, RD_LAT=1.
- Full pass: mask=3'b111, memory bank b index i = 16*b+i, start at cycle 0.
  - First rd_en at cycle 1 (bank0, addr0).
  - dis_data=0x00 and dis_en=1 at cycle 3.
  - 12 results shown in order 0x00..0x03, 0x10..0x13, 0x20..0x23, each 4 cycles.
  - done pulses exactly once; busy falls the cycle after.
- Sparse mask: mask=3'b100.
  - Only bank 2 is read; dis_bank=2 throughout.
  - Exactly 4 rd_en pulses before done.
- Empty mask: mask=0.
  - done at cycle 1, busy=1 only at cycle 1, no rd_en, dis_en stays 0.
- Skip: assert skip on the first SHOW cycle of each result.
  - Each result shows 1 cycle.
  - skip coincident with counter==3 advances once; no index is skipped.
- Reset mid-pass: drop rst_n during bank1 index2 SHOW.
  - All outputs 0 immediately (async), no done.
  - A new start after release begins again at bank0 index0.
- Start while busy: pulse start with mask=3'b001 mid-pass under mask=3'b111.
  - Ignored; all 12 results are still shown.
  - With DISP_HOLD_EN: hold for 10 cycles in SHOW stretches that result to 14 cycles.
